// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and line-level constants for the UART transmit path
package uart_pkg;
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} uart_state_e;
    localparam int DATA_BITS = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word valid/ready handshake between a word producer and uart_word_tx
//   word_valid  producer -> tx  word_in holds a word to send
//   word_in     producer -> tx  word to transmit (8*WORD_BYTES bits)
//   word_ready  tx -> producer  transmitter can accept a word this cycle
interface uart_word_tx_if #(parameter int WORD_BYTES = 2);
    logic word_valid;
    logic [8*WORD_BYTES-1:0] word_in;
    logic word_ready;
    modport master(output word_valid, word_in, input word_ready);
    modport slave(input word_valid, word_in, output word_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serialises one byte per handshake as an 8N1 frame (START/DATA/STOP)
//   clk_in, reset  system clock, synchronous active-high reset
//   clk_en         baud enable, one pulse per bit period
//   byte_valid     byte_in holds the next byte to frame
//   byte_in        byte to send, LSB first
//   byte_ready     idle, or in the final stop-bit period (lets the parent chain bytes gaplessly)
//   tx_data        registered serial line, idle high
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic                 byte_valid,
    input  logic [DATA_BITS-1:0] byte_in,
    output logic                 byte_ready,
    output logic                 tx_data
);
    uart_state_e state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic [1:0] stop_cnt_q;
    logic tx_q;
    logic last_stop;

    assign last_stop = state_q == STOP && stop_cnt_q == 2'(STOP_BITS - 1);
    assign byte_ready = state_q == IDLE || last_stop;
    assign tx_data = tx_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_cnt_q <= '0;
            stop_cnt_q <= '0;
            tx_q <= IDLE_LEVEL;
        end else if (clk_en) begin
            case (state_q)
                START: begin
                    state_q <= DATA;
                    tx_q <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    bit_cnt_q <= '0;
                end
                DATA: begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_q <= STOP;
                        tx_q <= IDLE_LEVEL;
                        stop_cnt_q <= '0;
                    end else begin
                        tx_q <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                default: begin
                    // IDLE or STOP: a waiting byte starts its frame on this very enable
                    if (byte_ready && byte_valid) begin
                        state_q <= START;
                        tx_q <= START_LEVEL;
                        shift_q <= byte_in;
                    end else if (last_stop || state_q != STOP) begin
                        state_q <= IDLE;
                    end else begin
                        stop_cnt_q <= stop_cnt_q + 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: accepts words over valid/ready and sends their bytes as back-to-back 8N1 frames
//   clk_in, reset  system clock, synchronous active-high reset
//   clk_en         baud enable (serial_clk), one pulse per bit period
//   w              word handshake (word_valid, word_in, word_ready), slave side
//   tx_data        serial line, idle high
//   busy           a word is being transmitted
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int WORD_BYTES = 2,
    parameter int MSB_FIRST = 1,
    parameter int STOP_BITS = 1
) (
    input  logic           clk_in,
    input  logic           reset,
    input  logic           clk_en,
    uart_word_tx_if.slave  w,
    output logic           tx_data,
    output logic           busy
);
    localparam int WW = DATA_BITS * WORD_BYTES;
    localparam int CW = $clog2(WORD_BYTES + 1);

    // Parent uses IDLE, ARM (waiting for the first enable) and DATA (word in flight)
    uart_state_e state_q;
    logic [WW-1:0] word_q;
    logic [CW-1:0] left_q;
    logic ready_q;
    logic busy_q;
    logic byte_valid;
    logic byte_ready;
    logic byte_fire;
    logic [DATA_BITS-1:0] cur_byte;

    // The word register shifts toward the sending end, so the current byte is always at one edge
    assign cur_byte = MSB_FIRST != 0 ? word_q[WW-1 -: DATA_BITS] : word_q[DATA_BITS-1:0];
    assign byte_valid = state_q == ARM || (state_q == DATA && left_q != '0);
    assign byte_fire = clk_en && byte_valid && byte_ready;
    assign w.word_ready = ready_q;
    assign busy = busy_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            word_q <= '0;
            left_q <= '0;
            ready_q <= 1'b1;
            busy_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (w.word_valid && ready_q) begin
                state_q <= ARM;
                word_q <= w.word_in;
                left_q <= CW'(WORD_BYTES);
                ready_q <= 1'b0;
                busy_q <= 1'b1;
            end
        end else if (byte_fire) begin
            state_q <= DATA;
            word_q <= MSB_FIRST != 0 ? word_q << DATA_BITS : word_q >> DATA_BITS;
            left_q <= left_q - 1'b1;
        end else if (state_q == DATA && clk_en && byte_ready && left_q == '0) begin
            // Final stop period of the last byte ends here
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q <= 1'b0;
        end
    end

    uart_tx_byte #(.STOP_BITS(STOP_BITS)) u_byte (
        .clk_in(clk_in),
        .reset(reset),
        .clk_en(clk_en),
        .byte_valid(byte_valid),
        .byte_in(cur_byte),
        .byte_ready(byte_ready),
        .tx_data(tx_data)
    );
endmodule
